// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the 6502 memory/bus controller slice.
// Optional build macro used elsewhere in this slice: ROM_WR_EN.
package bus_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GO   = 2'd2
    } wait_state_e;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_IO   = 2'd1,
        REG_ROM  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    localparam logic [7:0]  OPEN_BUS_DEF = 8'hEA;
    localparam logic [15:0] RESET_VEC    = 16'hC000;

    // IO wins over RAM, RAM over ROM, when windows overlap.
    function automatic region_e decode_region(input logic ram_sel,
                                              input logic io_sel,
                                              input logic rom_sel);
        if (io_sel)       return REG_IO;
        else if (ram_sel) return REG_RAM;
        else if (rom_sel) return REG_ROM;
        else              return REG_NONE;
    endfunction

endpackage

// File: rtl/bus_wait_fsm.sv
// Wait-state generator: stalls the CPU via RDY for WAIT_STATES cycles on every
// IO access, then lets the access complete.
module bus_wait_fsm
    import bus_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic io_sel_i,
    output logic rdy_o
);

    localparam bit STALL_EN = (WAIT_STATES > 0);
    localparam int WCNT_W   = (WAIT_STATES > 2) ? $clog2(WAIT_STATES - 1) : 1;
    // The S_IDLE cycle is the first stall, so S_WAIT covers the remaining WAIT_STATES-1.
    localparam logic [WCNT_W-1:0] WCNT_LOAD =
        WCNT_W'((WAIT_STATES > 2) ? (WAIT_STATES - 2) : 0);

    wait_state_e       state_q;
    logic [WCNT_W-1:0] wcnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io_sel_i && STALL_EN) begin
                        wcnt_q  <= WCNT_LOAD;
                        state_q <= (WAIT_STATES > 1) ? S_WAIT : S_GO;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == '0) begin
                        state_q <= S_GO;
                    end else begin
                        wcnt_q <= wcnt_q - WCNT_W'(1);
                    end
                end
                S_GO:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RDY has to drop in the same cycle the IO address appears, hence combinational.
    always_comb begin
        rdy_o = 1'b1;
        if (reset) begin
            case (state_q)
                S_IDLE:  rdy_o = !(io_sel_i && STALL_EN);
                S_WAIT:  rdy_o = 1'b0;
                default: rdy_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/bus_mem_ctrl.sv
// Decoded RAM / wait-stated IO / ROM / open-bus map for the Arlet 6502 core,
// with run-complete marker, cycle counter and timeout. Build macro: ROM_WR_EN.
module bus_mem_ctrl
    import bus_mem_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                RAM_DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'h8000,
    parameter int                IO_DEPTH    = 16,
    parameter int                WAIT_STATES = 2,
    parameter int                ROM_DEPTH   = 16384,
    parameter logic [DATA_W-1:0] OPEN_BUS    = OPEN_BUS_DEF,
    parameter logic [ADDR_W-1:0] MARKER_ADDR = 16'h8004,
    parameter logic [DATA_W-1:0] MARKER_VAL  = 8'hFF,
    parameter int                TIMEOUT     = 1000,
    parameter int                CNT_W       = 16,
    parameter string             ROM_FILE    = "rom.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ab,
    input  logic [DATA_W-1:0] dout,
    input  logic              we,
    output logic              rdy,
    output logic [DATA_W-1:0] di,
    output logic              done,
    output logic              timeout,
    output logic              rom_wr_err,
    output logic [CNT_W-1:0]  cycles
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int IO_AW  = $clog2(IO_DEPTH);
    localparam int ROM_AW = $clog2(ROM_DEPTH);

    // One extra bit so windows ending exactly at 2^ADDR_W compare correctly.
    localparam logic [ADDR_W:0] RAM_LIM = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [ADDR_W:0] IO_LO   = {1'b0, IO_BASE};
    localparam logic [ADDR_W:0] IO_HI   = IO_LO + (ADDR_W + 1)'(IO_DEPTH);
    localparam logic [ADDR_W:0] ROM_LO  = (ADDR_W + 1)'((1 << ADDR_W) - ROM_DEPTH);

    logic [ADDR_W:0]   ab_x;
    logic              ram_sel;
    logic              io_sel;
    logic              rom_sel;
    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [IO_AW-1:0]  io_idx;
    logic [ROM_AW-1:0] rom_idx;
    logic              wr_commit;
    logic              done_set;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [DATA_W-1:0] io_q  [IO_DEPTH];
    logic [DATA_W-1:0] rom_q [ROM_DEPTH];

    logic [DATA_W-1:0] di_q;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              rom_wr_err_q, rom_wr_err_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;

    // ROM is top-aligned and a power of two, so the low address bits index it directly.
    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) begin
            rom_q[i] = '0;
        end
        rom_q[ROM_DEPTH - 4] = DATA_W'(RESET_VEC[7:0]);
        rom_q[ROM_DEPTH - 3] = DATA_W'(RESET_VEC[15:8]);
    end

    assign ab_x    = {1'b0, ab};
    assign ram_sel = (ab_x < RAM_LIM);
    assign io_sel  = (ab_x >= IO_LO) && (ab_x < IO_HI);
    assign rom_sel = (ab_x >= ROM_LO);
    assign region  = decode_region(ram_sel, io_sel, rom_sel);

    assign ram_idx = ab[RAM_AW-1:0];
    assign io_idx  = IO_AW'(ab - IO_BASE);
    assign rom_idx = ab[ROM_AW-1:0];

    bus_wait_fsm #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_fsm (
        .clk      (clk),
        .reset    (reset),
        .io_sel_i (io_sel),
        .rdy_o    (rdy)
    );

    // rdy is forced high during reset, so reset must gate commits explicitly.
    assign wr_commit = reset && we && rdy;

    always_comb begin
        rd_data = OPEN_BUS;
        case (region)
            REG_RAM: rd_data = ram_q[ram_idx];
            REG_IO:  rd_data = io_q[io_idx];
            REG_ROM: rd_data = rom_q[rom_idx];
            default: rd_data = OPEN_BUS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            case (region)
                REG_RAM: ram_q[ram_idx] <= dout;
                REG_IO:  io_q[io_idx]   <= dout;
`ifdef ROM_WR_EN
                REG_ROM: rom_q[rom_idx] <= dout;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        done_set  = wr_commit && (ab == MARKER_ADDR) && (dout == MARKER_VAL);
        done_d    = done_q | done_set;
        // A marker landing on the timeout cycle wins: only done is raised.
        timeout_d = timeout_q |
                    (!done_q && !done_set && (cycles_q == CNT_W'(TIMEOUT - 1)));
        cycles_d  = cycles_q;
        if (!done_q && (cycles_q != {CNT_W{1'b1}})) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
`ifdef ROM_WR_EN
        rom_wr_err_d = 1'b0;
`else
        rom_wr_err_d = rom_wr_err_q | (wr_commit && (region == REG_ROM));
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            di_q         <= OPEN_BUS;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            rom_wr_err_q <= 1'b0;
            cycles_q     <= '0;
        end else begin
            di_q         <= rd_data;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            rom_wr_err_q <= rom_wr_err_d;
            cycles_q     <= cycles_d;
        end
    end

    assign di         = di_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign rom_wr_err = rom_wr_err_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed and randomized bus-level bench for bus_mem_ctrl against a
// transaction-level memory map and flag model.
module tb_bus_mem_ctrl;

    localparam int         WS = 2;
    localparam int         TO = 20;
    localparam int         CW = 6;
    localparam int         CMAX = (1 << CW) - 1;
    localparam logic [7:0] OB = 8'hEA;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          we    = 1'b0;
    logic [15:0]   ab    = 16'h4000;
    logic [7:0]    dout  = 8'h00;
    logic          rdy;
    logic [7:0]    di;
    logic          done;
    logic          timeout;
    logic          rom_wr_err;
    logic [CW-1:0] cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: known memory bytes, edges since release, edge of marker.
    logic [7:0] mem_m [int];
    int         n_edges   = 0;
    int         done_at   = 0;
    bit         rom_err_m = 1'b0;

    bus_mem_ctrl #(
        .WAIT_STATES (WS),
        .TIMEOUT     (TO),
        .CNT_W       (CW),
        .ROM_FILE    ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ab         (ab),
        .dout       (dout),
        .we         (we),
        .rdy        (rdy),
        .di         (di),
        .done       (done),
        .timeout    (timeout),
        .rom_wr_err (rom_wr_err),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = RAM, 1 = IO, 2 = ROM, 3 = unmapped
    function automatic int region_of(input logic [15:0] a);
        if (a >= 16'h8000 && a < 16'h8010) return 1;
        if (a < 16'h1000) return 0;
        if (a >= 16'hC000) return 2;
        return 3;
    endfunction

    function automatic void exp_read(input logic [15:0] a, output logic [7:0] v, output bit known);
        known = 1'b1;
        v     = OB;
        case (region_of(a))
            0, 1: begin
                if (mem_m.exists(int'(a))) v = mem_m[int'(a)];
                else known = 1'b0;
            end
            2: begin
                if (mem_m.exists(int'(a))) v = mem_m[int'(a)];
                else v = (a == 16'hFFFD) ? 8'hC0 : 8'h00;
            end
            default: v = OB;
        endcase
    endfunction

    function automatic int exp_cycles();
        int n;
        n = (done_at != 0) ? done_at : n_edges;
        return (n > CMAX) ? CMAX : n;
    endfunction

    function automatic bit exp_timeout();
        if (done_at != 0) return (done_at > TO);
        return (n_edges >= TO);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) n_edges++;
        #1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, ".done"},    32'(done),       32'(done_at != 0));
        chk({tag, ".timeout"}, 32'(timeout),    32'(exp_timeout()));
        chk({tag, ".romerr"},  32'(rom_wr_err), 32'(rom_err_m));
        chk({tag, ".cycles"},  32'(cycles),     32'(exp_cycles()));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        we    = 1'b0;
        ab    = 16'h4000;
        repeat (n) tick();
        chk("rst.di",   32'(di),  32'(OB));
        chk("rst.rdy",  32'(rdy), 32'(1));
        reset     = 1'b1;
        n_edges   = 0;
        done_at   = 0;
        rom_err_m = 1'b0;
        #1;
        chk("rel.rdy", 32'(rdy), 32'(1));
        check_flags("rel");
    endtask

    // One CPU bus cycle: hold the address until RDY, then take the committing edge.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d, input string tag);
        int         stalls;
        logic [7:0] ev;
        bit         known;
        stalls = 0;
        exp_read(a, ev, known);
        ab   = a;
        we   = w;
        dout = d;
        #1;
        while (rdy !== 1'b1 && stalls < 20) begin
            tick();
            stalls++;
        end
        chk({tag, ".stalls"}, 32'(stalls), 32'((region_of(a) == 1) ? WS : 0));
        tick();
        if (!w && known) chk({tag, ".di"}, 32'(di), 32'(ev));
        if (w) begin
            case (region_of(a))
                0, 1: mem_m[int'(a)] = d;
                2: begin
`ifdef ROM_WR_EN
                    mem_m[int'(a)] = d;
`else
                    rom_err_m = 1'b1;
`endif
                end
                default: ;
            endcase
            if (a == 16'h8004 && d == 8'hFF && done_at == 0) done_at = n_edges;
        end
        ab = 16'h4000;
        we = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rd;
        int          r;

        // Reset and first cycles
        do_reset(10);
        repeat (5) tick();
        chk("cnt5", 32'(cycles), 32'(5));
        check_flags("idle5");

        // CPU program: STA $0200, LDA $0200, STA $8004 with $FF
        access(16'h0200, 1'b1, 8'h42, "sta_ram");
        access(16'h0200, 1'b0, 8'h00, "lda_ram");
        chk("lda_ram.val", 32'(di), 32'(8'h42));
        access(16'h8004, 1'b1, 8'hFF, "marker");
        check_flags("marker");
        repeat (25) tick();
        check_flags("frozen");

        // IO wait states, back to back
        access(16'h8001, 1'b1, 8'h33, "io_wr");
        access(16'h8001, 1'b0, 8'h00, "io_rd");
        chk("io_rd.val", 32'(di), 32'(8'h33));

        // ROM write protection and reset vector
        access(16'hC010, 1'b1, 8'h55, "rom_wr");
        access(16'hC010, 1'b0, 8'h00, "rom_rd");
        check_flags("rom");
        access(16'hFFFC, 1'b0, 8'h00, "vec_lo");
        access(16'hFFFD, 1'b0, 8'h00, "vec_hi");
        chk("vec_hi.val", 32'(di), 32'(8'hC0));

        // Unmapped
        access(16'h4000, 1'b0, 8'h00, "unm_rd");
        access(16'h4000, 1'b1, 8'h12, "unm_wr");
        access(16'h4000, 1'b0, 8'h00, "unm_rd2");
        chk("unm.val", 32'(di), 32'(OB));
        check_flags("unm");

        // Timeout without marker, then counter saturation
        do_reset(3);
        for (int i = 0; i < 70; i++) begin
            tick();
            chk("to.timeout", 32'(timeout), 32'(exp_timeout()));
            chk("to.cycles",  32'(cycles),  32'(exp_cycles()));
        end

        // Reset asserted in the middle of an IO stall
        do_reset(2);
        access(16'h8002, 1'b1, 8'h11, "io_pre");
        ab   = 16'h8002;
        we   = 1'b1;
        dout = 8'h77;
        #1;
        chk("mid.rdy0", 32'(rdy), 32'(0));
        tick();
        chk("mid.rdy1", 32'(rdy), 32'(0));
        reset = 1'b0;
        #1;
        chk("mid.rdy_rst", 32'(rdy), 32'(1));
        tick();
        reset     = 1'b1;
        n_edges   = 0;
        done_at   = 0;
        rom_err_m = 1'b0;
        ab        = 16'h4000;
        we        = 1'b0;
        #1;
        chk("mid.rdy_idle", 32'(rdy), 32'(1));
        check_flags("mid");
        access(16'h8002, 1'b0, 8'h00, "mid_rd");
        chk("mid_rd.val", 32'(di), 32'(8'h11));

        // Randomized traffic over all regions
        do_reset(2);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: ra = 16'($urandom_range(0, 31)) * 16'd128;
                1: ra = 16'h8000 + 16'($urandom_range(0, 15));
                2: ra = ($urandom_range(0, 1) == 0) ? 16'hC000 + 16'($urandom_range(0, 15))
                                                     : 16'hFFF0 + 16'($urandom_range(0, 15));
                default: ra = ($urandom_range(0, 1) == 0) ? 16'h1000 + 16'($urandom_range(0, 255))
                                                          : 16'h9000 + 16'($urandom_range(0, 255));
            endcase
            rd = 8'($urandom_range(0, 255));
            access(ra, 1'($urandom_range(0, 1)), rd, "rand");
            if ((i % 25) == 0) check_flags("rand");
        end
        check_flags("rand_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
